// File: rtl/coderom_loader_pkg.sv
// Shared constants and state encoding for the code ROM writer and reader.
package coderom_loader_pkg;

    localparam int unsigned CODEROM_BANK_AW    = 13;
    localparam int unsigned CODEROM_NBANKS     = 4;
    localparam int unsigned CODEROM_IMAGE_SIZE = CODEROM_NBANKS << CODEROM_BANK_AW;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_CK_HI  = 3'd4,
        ST_CK_LO  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

endpackage

// File: rtl/coderom_bank_decode.sv
// Bank select decoder: bank index plus strobe -> one-hot active-low write enables.
module coderom_bank_decode #(
    parameter int unsigned NBANKS = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic [SEL_W-1:0]  bank_i,
    input  logic              strobe_i,
    output logic [NBANKS-1:0] we_n_o
);

    // Drive low only the selected bank, and only while strobing.
    always_comb begin
        we_n_o = '1;
        if (strobe_i) begin
            for (int unsigned b = 0; b < NBANKS; b++) begin
                if (SEL_W'(b) == bank_i) begin
                    we_n_o[b] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/coderom_loader.sv
// Code ROM loader: writes a valid/ready byte stream sequentially into the ROM
// banks and holds the CPU in reset until the whole image is in place.
// Optional trailer checksum verification: define CODEROM_LOADER_CKSUM_EN.
module coderom_loader
    import coderom_loader_pkg::*;
#(
    parameter int unsigned BANK_AW = CODEROM_BANK_AW,
    parameter int unsigned NBANKS  = CODEROM_NBANKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [BANK_AW-1:0] wr_a,
    output logic [7:0]         wr_d,
    output logic [NBANKS-1:0]  wr_we_n,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_hold
);

    localparam int unsigned ADDR_W = BANK_AW + $clog2(NBANKS);
    localparam int unsigned SEL_W  = (NBANKS > 1) ? $clog2(NBANKS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((NBANKS << BANK_AW) - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BANK_AW-1:0]  wr_a_q, wr_a_d;
    logic [7:0]          wr_d_q, wr_d_d;
    logic [NBANKS-1:0]   we_n_q, we_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                hold_q, hold_d;
`ifdef CODEROM_LOADER_CKSUM_EN
    logic [15:0]         sum_q, sum_d;
    logic [7:0]          ck_hi_q, ck_hi_d;
    logic                error_q, error_d;
`endif

    logic [SEL_W-1:0]    bank_sel;
    logic [NBANKS-1:0]   dec_we_n;

    assign bank_sel = SEL_W'(addr_q >> BANK_AW);

    coderom_bank_decode #(
        .NBANKS (NBANKS),
        .SEL_W  (SEL_W)
    ) u_decode (
        .bank_i   (bank_sel),
        .strobe_i (in_valid && (state_q == ST_ACCEPT)),
        .we_n_o   (dec_we_n)
    );

    // Next-state, datapath and status flag logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wr_a_d   = wr_a_q;
        wr_d_d   = wr_d_q;
        we_n_d   = we_n_q;
        busy_d   = busy_q;
        done_d   = done_q;
        hold_d   = hold_q;
        in_ready = 1'b0;
`ifdef CODEROM_LOADER_CKSUM_EN
        sum_d    = sum_q;
        ck_hi_d  = ck_hi_q;
        error_d  = error_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_ACCEPT;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    hold_d  = 1'b1;
`ifdef CODEROM_LOADER_CKSUM_EN
                    sum_d   = '0;
                    error_d = 1'b0;
`endif
                end
            end
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_d_d  = in_data;
                    wr_a_d  = addr_q[BANK_AW-1:0];
                    we_n_d  = dec_we_n;
`ifdef CODEROM_LOADER_CKSUM_EN
                    sum_d   = sum_q + 16'(in_data);
`endif
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                we_n_d  = '1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Address and data stay put for one cycle after the strobe rises.
                if (addr_q == LAST_ADDR) begin
`ifdef CODEROM_LOADER_CKSUM_EN
                    state_d = ST_CK_HI;
`else
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = ST_ACCEPT;
                end
            end
`ifdef CODEROM_LOADER_CKSUM_EN
            ST_CK_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ck_hi_d = in_data;
                    state_d = ST_CK_LO;
                end
            end
            ST_CK_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    busy_d = 1'b0;
                    if ({ck_hi_q, in_data} == sum_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset releases any active strobe at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wr_a_q  <= '0;
            wr_d_q  <= '0;
            we_n_q  <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
`ifdef CODEROM_LOADER_CKSUM_EN
            sum_q   <= '0;
            ck_hi_q <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_a_q  <= wr_a_d;
            wr_d_q  <= wr_d_d;
            we_n_q  <= we_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hold_q  <= hold_d;
`ifdef CODEROM_LOADER_CKSUM_EN
            sum_q   <= sum_d;
            ck_hi_q <= ck_hi_d;
            error_q <= error_d;
`endif
        end
    end

    assign wr_a     = wr_a_q;
    assign wr_d     = wr_d_q;
    assign wr_we_n  = we_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cpu_hold = hold_q;
`ifdef CODEROM_LOADER_CKSUM_EN
    assign error    = error_q;
`else
    assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_coderom_loader.sv
// Testbench for coderom_loader with a reduced image (4 banks x 32 bytes).
// Honours CODEROM_LOADER_CKSUM_EN the same way the design does.
module tb_coderom_loader;

    localparam int unsigned BANK_AW = 5;
    localparam int unsigned NBANKS  = 4;
    localparam int BSZ   = 1 << BANK_AW;
    localparam int N     = NBANKS * BSZ;
    localparam int LOG_N = 4096;

    logic               clk = 1'b0;
    logic               reset, start, in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic [BANK_AW-1:0] wr_a;
    logic [7:0]         wr_d;
    logic [NBANKS-1:0]  wr_we_n;
    logic               busy, done, error, cpu_hold;

    always #5 clk = ~clk;

    coderom_loader #(
        .BANK_AW (BANK_AW),
        .NBANKS  (NBANKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_a     (wr_a),
        .wr_d     (wr_d),
        .wr_we_n  (wr_we_n),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .cpu_hold (cpu_hold)
    );

    int vectors = 0;
    int miscompares = 0;
    int gen = 0;

    // Reference image and stream, and what the ROM banks actually received.
    logic [7:0]         src[$];
    int                 exp_img[N];
    logic [7:0]         trailer_hi, trailer_lo;
    int                 cap_val[N];
    int                 cap_gen[N];
    int                 strobe_cnt = 0;
    int                 multi_low_cnt = 0;
    logic [NBANKS-1:0]  we_log[LOG_N];
    logic [BANK_AW-1:0] a_log[LOG_N];

    function automatic int low_count(input logic [NBANKS-1:0] v);
        int c = 0;
        for (int b = 0; b < NBANKS; b++) if (v[b] === 1'b0) c++;
        return c;
    endfunction

    function automatic int low_index(input logic [NBANKS-1:0] v);
        int k = 0;
        for (int b = 0; b < NBANKS; b++) if (v[b] === 1'b0) k = b;
        return k;
    endfunction

    // ROM bank model: records every strobed write.
    always @(negedge clk) begin
        if (wr_we_n !== '1) begin
            if (low_count(wr_we_n) != 1) multi_low_cnt <= multi_low_cnt + 1;
            cap_val[low_index(wr_we_n) * BSZ + int'(wr_a)] <= int'(wr_d);
            cap_gen[low_index(wr_we_n) * BSZ + int'(wr_a)] <= gen;
            if (strobe_cnt < LOG_N) begin
                we_log[strobe_cnt] <= wr_we_n;
                a_log[strobe_cnt]  <= wr_a;
            end
            strobe_cnt <= strobe_cnt + 1;
        end
    end

    task automatic build_image(input bit rand_data, input bit bad_trailer);
        int sum = 0;
        logic [7:0] b;
        src.delete();
        for (int a = 0; a < N; a++) begin
            b = rand_data ? 8'($urandom) : 8'((a ^ (a >> 8)) & 255);
            exp_img[a] = int'(b);
            sum = (sum + int'(b)) % 65536;
            src.push_back(b);
        end
        trailer_hi = 8'(sum >> 8);
        trailer_lo = bad_trailer ? 8'(sum + 1) : 8'(sum);
`ifdef CODEROM_LOADER_CKSUM_EN
        src.push_back(trailer_hi);
        src.push_back(trailer_lo);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Source model: offers src[] with random idle gaps, optional start pulse at byte start_at.
    task automatic send_stream(input int gap_pct, input int start_at,
                               output int iters, output int readies, output bit ok);
        int idx = 0;
        bit pulsed = 0;
        iters = 0;
        readies = 0;
        while (idx < src.size() && iters < 20 * N) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = src[idx];
            start    = (start_at >= 0 && idx == start_at && !pulsed);
            if (start) pulsed = 1;
            @(negedge clk);
            if (in_ready === 1'b1) readies++;
            if (in_valid && in_ready === 1'b1) idx++;
            @(posedge clk); #1;
            iters++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        ok = (idx == src.size());
    endtask

    task automatic wait_end(output bit ok);
        int c = 0;
        while (done !== 1'b1 && error !== 1'b1 && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        ok = (done === 1'b1 || error === 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #3;
        vectors += 8;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
        if (wr_we_n !== 4'b1111) begin miscompares++; $display("FAIL reset_we_n: got %b need 1111", wr_we_n); end
        if (wr_a !== '0) begin miscompares++; $display("FAIL reset_wr_a: got %h need 0", wr_a); end
        if (wr_d !== 8'h00) begin miscompares++; $display("FAIL reset_wr_d: got %h need 00", wr_d); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b need 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b need 0", done); end
        if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b need 0", error); end
        if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_hold: got %b need 1", cpu_hold); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_strobe();
        bit seen = 0;
        int c = 0;
        int base;
        gen++;
        build_image(0, 0);
        pulse_start();
        in_valid = 1'b1;
        in_data  = src[0];
        while (!seen && c < 20) begin
            @(negedge clk);
            if (wr_we_n !== '1) seen = 1;
            c++;
        end
        vectors++;
        if (!seen) begin miscompares++; $display("FAIL midstrobe_reach: no strobe within %0d cycles", c); end
        #2 reset = 1'b1;
        #1;
        vectors += 4;
        if (wr_we_n !== 4'b1111) begin miscompares++; $display("FAIL midstrobe_we_n: got %b need 1111", wr_we_n); end
        if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL midstrobe_cpu_hold: got %b need 1", cpu_hold); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL midstrobe_busy: got %b need 0", busy); end
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midstrobe_in_ready: got %b need 0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        base = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL midstrobe_idle_ready: cycle %0d got %b need 0", i, in_ready); end
        end
        in_valid = 1'b0;
        vectors++;
        if (strobe_cnt != base) begin miscompares++; $display("FAIL midstrobe_no_write: got %0d strobes need 0", strobe_cnt - base); end
        @(posedge clk); #1;
    endtask

    task automatic test_sequential();
        int iters, readies, base, mbase, exp_iters, exp_ready;
        bit ok;
        gen++;
        base = strobe_cnt;
        mbase = multi_low_cnt;
        build_image(0, 0);
        pulse_start();
        send_stream(0, -1, iters, readies, ok);
`ifdef CODEROM_LOADER_CKSUM_EN
        exp_iters = 3 * N + 2; exp_ready = N + 2;
`else
        exp_iters = 3 * N - 2; exp_ready = N;
`endif
        vectors += 3;
        if (!ok) begin miscompares++; $display("FAIL seq_stream: stream not consumed after %0d cycles", iters); end
        if (iters != exp_iters) begin miscompares++; $display("FAIL seq_cycles: got %0d need %0d", iters, exp_iters); end
        if (readies != exp_ready) begin miscompares++; $display("FAIL seq_ready_duty: got %0d need %0d", readies, exp_ready); end
        wait_end(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL seq_end: no done/error (got done=%b) need done=1", done); end
        @(posedge clk); #1;
        vectors += 4;
        if (done !== 1'b1) begin miscompares++; $display("FAIL seq_done: got %b need 1", done); end
        if (error !== 1'b0) begin miscompares++; $display("FAIL seq_error: got %b need 0", error); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL seq_busy: got %b need 0", busy); end
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL seq_cpu_hold: got %b need 0", cpu_hold); end
        for (int a = 0; a < N; a++) begin
            vectors++;
            if (cap_gen[a] != gen || cap_val[a] != exp_img[a]) begin
                miscompares++; $display("FAIL seq_image[%0d]: got %h need %h", a, cap_val[a], exp_img[a]);
            end
        end
        vectors += 4;
        if (strobe_cnt - base != N) begin miscompares++; $display("FAIL seq_strobes: got %0d need %0d", strobe_cnt - base, N); end
        if (multi_low_cnt != mbase) begin miscompares++; $display("FAIL seq_onehot: got %0d bad strobes need 0", multi_low_cnt - mbase); end
        if (we_log[base + BSZ] !== 4'b1101) begin miscompares++; $display("FAIL seq_bank1_we_n: got %b need 1101", we_log[base + BSZ]); end
        if (a_log[base + BSZ] !== '0) begin miscompares++; $display("FAIL seq_bank1_wr_a: got %h need 0", a_log[base + BSZ]); end
    endtask

    task automatic test_random_gaps();
        int iters, readies, base;
        bit ok;
        gen++;
        base = strobe_cnt;
        build_image(1, 0);
        pulse_start();
        send_stream(30, -1, iters, readies, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL gaps_stream: stream not consumed after %0d cycles", iters); end
        wait_end(ok);
        vectors += 2;
        if (!ok || done !== 1'b1) begin miscompares++; $display("FAIL gaps_done: got %b need 1", done); end
        if (strobe_cnt - base != N) begin miscompares++; $display("FAIL gaps_strobes: got %0d need %0d", strobe_cnt - base, N); end
        for (int a = 0; a < N; a++) begin
            vectors++;
            if (cap_gen[a] != gen || cap_val[a] != exp_img[a]) begin
                miscompares++; $display("FAIL gaps_image[%0d]: got %h need %h", a, cap_val[a], exp_img[a]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int iters, readies, base;
        bit ok;
        gen++;
        base = strobe_cnt;
        build_image(0, 0);
        pulse_start();
        vectors += 3;
        if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reload_cpu_hold: got %b need 1", cpu_hold); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reload_done: got %b need 0", done); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL reload_busy: got %b need 1", busy); end
        send_stream(0, 100, iters, readies, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL busystart_stream: stream not consumed after %0d cycles", iters); end
        wait_end(ok);
        @(posedge clk); #1;
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL busystart_done: got %b need 1", done); end
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL busystart_cpu_hold: got %b need 0", cpu_hold); end
        if (strobe_cnt - base != N) begin miscompares++; $display("FAIL busystart_strobes: got %0d need %0d", strobe_cnt - base, N); end
        for (int a = 0; a < N; a++) begin
            vectors++;
            if (cap_gen[a] != gen || cap_val[a] != exp_img[a]) begin
                miscompares++; $display("FAIL busystart_image[%0d]: got %h need %h", a, cap_val[a], exp_img[a]);
            end
        end
    endtask

`ifdef CODEROM_LOADER_CKSUM_EN
    task automatic test_checksum();
        int iters, readies;
        bit ok;
        gen++;
        build_image(1, 1);
        pulse_start();
        send_stream(20, -1, iters, readies, ok);
        wait_end(ok);
        @(posedge clk); #1;
        vectors += 5;
        if (!ok) begin miscompares++; $display("FAIL ck_bad_end: no done/error, need error=1"); end
        if (error !== 1'b1) begin miscompares++; $display("FAIL ck_bad_error: got %b need 1", error); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL ck_bad_done: got %b need 0", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL ck_bad_busy: got %b need 0", busy); end
        if (cpu_hold !== 1'b1) begin miscompares++; $display("FAIL ck_bad_cpu_hold: got %b need 1", cpu_hold); end
        gen++;
        build_image(1, 0);
        pulse_start();
        vectors++;
        if (error !== 1'b0) begin miscompares++; $display("FAIL ck_restart_error: got %b need 0", error); end
        send_stream(20, -1, iters, readies, ok);
        wait_end(ok);
        @(posedge clk); #1;
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL ck_good_done: got %b need 1", done); end
        if (error !== 1'b0) begin miscompares++; $display("FAIL ck_good_error: got %b need 0", error); end
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL ck_good_cpu_hold: got %b need 0", cpu_hold); end
        for (int a = 0; a < N; a++) begin
            vectors++;
            if (cap_gen[a] != gen || cap_val[a] != exp_img[a]) begin
                miscompares++; $display("FAIL ck_image[%0d]: got %h need %h", a, cap_val[a], exp_img[a]);
            end
        end
    endtask
`else
    task automatic test_extra_bytes();
        int base = strobe_cnt;
        in_valid = 1'b1;
        in_data  = trailer_hi;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL extra_in_ready: cycle %0d got %b need 0", i, in_ready); end
            in_data = trailer_lo;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        vectors += 3;
        if (strobe_cnt != base) begin miscompares++; $display("FAIL extra_no_strobe: got %0d strobes need 0", strobe_cnt - base); end
        if (done !== 1'b1) begin miscompares++; $display("FAIL extra_done: got %b need 1", done); end
        if (cpu_hold !== 1'b0) begin miscompares++; $display("FAIL extra_cpu_hold: got %b need 0", cpu_hold); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_strobe();
        test_sequential();
        test_random_gaps();
        test_start_while_busy();
`ifdef CODEROM_LOADER_CKSUM_EN
        test_checksum();
`else
        test_extra_bytes();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

endmodule
